// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for an N-stage in-order pipeline: memory back-pressure,
// branch redirect with refill penalty, load-use bubbles and saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int EX_STAGE   = 2,
  parameter int MEM_STAGE  = 3,
  parameter int REG_AW     = 5,
  parameter int BR_PENALTY = 1,
  parameter int LU_STALL   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  dec_valid_i,
  input  logic [REG_AW-1:0]     dec_rs1_addr_i,
  input  logic [REG_AW-1:0]     dec_rs2_addr_i,
  input  logic                  dec_rs1_used_i,
  input  logic                  dec_rs2_used_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_is_load_i,
  input  logic [REG_AW-1:0]     ex_rd_addr_i,
  input  logic                  ex_rd_write_en_i,
  input  logic                  branch_en_i,
  input  logic                  mem_busy_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU       = 2'b01,
    ST_FLUSH    = 2'b10,
    ST_MEM_WAIT = 2'b11
  } state_t;

  state_t           state_q, state_d;
  state_t           saved_q, saved_d;
  state_t           eff_state;
  logic [2:0]       br_cnt_q, br_cnt_d;
  logic [2:0]       lu_cnt_q, lu_cnt_d;
  logic             br_pend_q, br_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic                  lu_hit;
  logic                  br_req;
  logic                  br_take;
  logic [NUM_STAGES-1:0] stall_raw;
  logic [NUM_STAGES-1:0] flush_raw;

  logic [NUM_STAGES-1:0] mem_stall_mask, mem_flush_mask;
  logic [NUM_STAGES-1:0] br_flush_mask, refill_mask;
  logic [NUM_STAGES-1:0] lu_stall_mask, lu_flush_mask;

  // Per-stage masks; the stage after MEM only gets a bubble if it exists.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_mask
      assign mem_stall_mask[gi] = (gi <= MEM_STAGE);
      assign mem_flush_mask[gi] = (gi == MEM_STAGE + 1);
      assign br_flush_mask[gi]  = (gi >= 1) && (gi <= EX_STAGE);
      assign refill_mask[gi]    = (gi == 1);
      assign lu_stall_mask[gi]  = (gi < EX_STAGE);
      assign lu_flush_mask[gi]  = (gi == EX_STAGE);
    end
  endgenerate

  assign lu_hit = dec_valid_i & ex_valid_i & ex_is_load_i & ex_rd_write_en_i &
                  (ex_rd_addr_i != '0) &
                  ((dec_rs1_used_i & (dec_rs1_addr_i == ex_rd_addr_i)) |
                   (dec_rs2_used_i & (dec_rs2_addr_i == ex_rd_addr_i)));

  // After a memory wait, the first free cycle behaves as the state that was interrupted.
  assign eff_state = (state_q == ST_MEM_WAIT) ? saved_q : state_q;
  assign br_req    = branch_en_i | br_pend_q;

  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    br_cnt_d  = br_cnt_q;
    lu_cnt_d  = lu_cnt_q;
    br_pend_d = br_pend_q;
    stall_raw = '0;
    flush_raw = '0;
    br_take   = 1'b0;

    if (mem_busy_i) begin
      stall_raw = mem_stall_mask;
      flush_raw = mem_flush_mask;
      state_d   = ST_MEM_WAIT;
      br_pend_d = br_req;
      if (state_q != ST_MEM_WAIT) begin
        saved_d = state_q;
      end
    end else if (br_req) begin
      flush_raw = br_flush_mask;
      br_take   = 1'b1;
      br_pend_d = 1'b0;
      lu_cnt_d  = '0;
      if (BR_PENALTY > 0) begin
        state_d  = ST_FLUSH;
        br_cnt_d = 3'(BR_PENALTY);
      end else begin
        state_d = ST_RUN;
      end
    end else if ((eff_state == ST_LU) || ((eff_state == ST_RUN) && lu_hit)) begin
      stall_raw = lu_stall_mask;
      flush_raw = lu_flush_mask;
      if (eff_state == ST_RUN) begin
        lu_cnt_d = 3'(LU_STALL - 1);
        state_d  = (LU_STALL > 1) ? ST_LU : ST_RUN;
      end else begin
        lu_cnt_d = lu_cnt_q - 3'd1;
        state_d  = (lu_cnt_q == 3'd1) ? ST_RUN : ST_LU;
      end
    end else if (eff_state == ST_FLUSH) begin
      // Decode holds a bubble during refill, so a load-use match here is meaningless.
      flush_raw = refill_mask;
      br_cnt_d  = br_cnt_q - 3'd1;
      state_d   = (br_cnt_q == 3'd1) ? ST_RUN : ST_FLUSH;
    end else begin
      state_d = ST_RUN;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_raw[0] && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if (br_take && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q     <= ST_RUN;
      saved_q     <= ST_RUN;
      br_cnt_q    <= '0;
      lu_cnt_q    <= '0;
      br_pend_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      br_cnt_q    <= br_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
      br_pend_q   <= br_pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_o     = resetn_i ? stall_raw : '0;
  assign flush_o     = resetn_i ? flush_raw : '1;
  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a per-cycle vector table plus hand-written
// sequences for counter saturation and asynchronous reset during refill.
module tb_pipe_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       resetn_i;
  logic       dec_valid_i;
  logic [4:0] dec_rs1_addr_i, dec_rs2_addr_i;
  logic       dec_rs1_used_i, dec_rs2_used_i;
  logic       ex_valid_i, ex_is_load_i;
  logic [4:0] ex_rd_addr_i;
  logic       ex_rd_write_en_i;
  logic       branch_en_i, mem_busy_i;
  logic [4:0] stall_o, flush_o;
  logic [1:0] state_o;
  logic [3:0] stall_cnt_o, flush_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl #(
    .NUM_STAGES(5), .EX_STAGE(2), .MEM_STAGE(3), .REG_AW(5),
    .BR_PENALTY(1), .LU_STALL(2), .CNT_W(4)
  ) dut (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .dec_valid_i(dec_valid_i), .dec_rs1_addr_i(dec_rs1_addr_i), .dec_rs2_addr_i(dec_rs2_addr_i),
    .dec_rs1_used_i(dec_rs1_used_i), .dec_rs2_used_i(dec_rs2_used_i),
    .ex_valid_i(ex_valid_i), .ex_is_load_i(ex_is_load_i), .ex_rd_addr_i(ex_rd_addr_i),
    .ex_rd_write_en_i(ex_rd_write_en_i), .branch_en_i(branch_en_i), .mem_busy_i(mem_busy_i),
    .stall_o(stall_o), .flush_o(flush_o), .state_o(state_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  typedef struct {
    logic       dv;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       exv;
    logic       ld;
    logic [4:0] rd;
    logic       we;
    logic       br;
    logic       busy;
    logic [4:0] stall;
    logic [4:0] flush;
    logic [1:0] st;
    logic [3:0] sc;
    logic [3:0] fc;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];

  function automatic vec_t v(logic dv, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                             logic exv, logic ld, logic [4:0] rd, logic we,
                             logic br, logic busy,
                             logic [4:0] stall, logic [4:0] flush, logic [1:0] st,
                             logic [3:0] sc, logic [3:0] fc);
    vec_t r;
    r.dv = dv; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
    r.exv = exv; r.ld = ld; r.rd = rd; r.we = we; r.br = br; r.busy = busy;
    r.stall = stall; r.flush = flush; r.st = st; r.sc = sc; r.fc = fc;
    return r;
  endfunction

  task automatic drive(input vec_t t);
    dec_valid_i      = t.dv;
    dec_rs1_addr_i   = t.rs1;
    dec_rs1_used_i   = t.u1;
    dec_rs2_addr_i   = t.rs2;
    dec_rs2_used_i   = t.u2;
    ex_valid_i       = t.exv;
    ex_is_load_i     = t.ld;
    ex_rd_addr_i     = t.rd;
    ex_rd_write_en_i = t.we;
    branch_en_i      = t.br;
    mem_busy_i       = t.busy;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vec_t z, luh;
    z   = v(0,0,0,0,0, 0,0,0,0, 0,0, 5'b0,5'b0,2'b00,4'd0,4'd0);
    luh = v(1,5,1,0,0, 1,1,5,1, 0,0, 5'b0,5'b0,2'b00,4'd0,4'd0);

    //            dv rs1 u1 rs2 u2 exv ld rd we br bz  stall     flush     st  sc  fc
    tbl[0]  = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'b00, 0, 0);
    tbl[1]  = v(1, 5, 1, 0, 0,  1, 1, 5, 1, 0, 0, 5'b00011, 5'b00100, 2'b00, 0, 0);
    tbl[2]  = v(1, 5, 1, 0, 0,  1, 1, 5, 1, 0, 0, 5'b00011, 5'b00100, 2'b01, 1, 0);
    tbl[3]  = v(1, 5, 1, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'b00, 2, 0);
    tbl[4]  = v(1, 0, 1, 0, 0,  1, 1, 0, 1, 0, 0, 5'b00000, 5'b00000, 2'b00, 2, 0);
    tbl[5]  = v(1, 5, 1, 7, 1,  1, 1, 7, 1, 0, 0, 5'b00011, 5'b00100, 2'b00, 2, 0);
    tbl[6]  = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00011, 5'b00100, 2'b01, 3, 0);
    tbl[7]  = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'b00, 4, 0);
    tbl[8]  = v(1, 5, 1, 0, 0,  1, 0, 5, 1, 0, 0, 5'b00000, 5'b00000, 2'b00, 4, 0);
    tbl[9]  = v(1, 5, 0, 0, 0,  1, 1, 5, 1, 0, 0, 5'b00000, 5'b00000, 2'b00, 4, 0);
    tbl[10] = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 5'b00000, 5'b00110, 2'b00, 4, 0);
    tbl[11] = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000, 5'b00010, 2'b10, 4, 1);
    tbl[12] = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'b00, 4, 1);
    tbl[13] = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 5'b01111, 5'b10000, 2'b00, 4, 1);
    tbl[14] = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 5'b01111, 5'b10000, 2'b11, 5, 1);
    tbl[15] = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 5'b01111, 5'b10000, 2'b11, 6, 1);
    tbl[16] = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000, 5'b00110, 2'b11, 7, 1);
    tbl[17] = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000, 5'b00010, 2'b10, 7, 2);
    tbl[18] = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'b00, 7, 2);
    tbl[19] = v(1, 5, 1, 0, 0,  1, 1, 5, 1, 1, 0, 5'b00000, 5'b00110, 2'b00, 7, 2);
    tbl[20] = v(1, 5, 1, 0, 0,  1, 1, 5, 1, 0, 0, 5'b00000, 5'b00010, 2'b10, 7, 3);
    tbl[21] = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'b00, 7, 3);
    tbl[22] = v(1, 5, 1, 0, 0,  1, 1, 5, 1, 0, 0, 5'b00011, 5'b00100, 2'b00, 7, 3);
    tbl[23] = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 5'b01111, 5'b10000, 2'b01, 8, 3);
    tbl[24] = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00011, 5'b00100, 2'b11, 9, 3);
    tbl[25] = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'b00, 10, 3);
    tbl[26] = v(1, 5, 1, 0, 0,  1, 1, 5, 1, 0, 0, 5'b00011, 5'b00100, 2'b00, 10, 3);
    tbl[27] = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 5'b00000, 5'b00110, 2'b01, 11, 3);
    tbl[28] = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000, 5'b00010, 2'b10, 11, 4);
    tbl[29] = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 2'b00, 11, 4);

    // Reset and initial state
    drive(z);
    resetn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_flush", 32'(flush_o), 32'h1F);
    chk("rst_stall", 32'(stall_o), 32'h00);
    resetn_i = 1'b1;
    #2;
    chk("post_rst_state", 32'(state_o), 32'h0);
    chk("post_rst_stall_cnt", 32'(stall_cnt_o), 32'h0);
    chk("post_rst_flush_cnt", 32'(flush_cnt_o), 32'h0);
    #1;

    // Per-cycle vector table
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      #2;
      $display("[TB] vec %0d: stall=%b flush=%b state=%b scnt=%0d fcnt=%0d",
               i, stall_o, flush_o, state_o, stall_cnt_o, flush_cnt_o);
      chk($sformatf("vec%0d_stall", i), 32'(stall_o), 32'(tbl[i].stall));
      chk($sformatf("vec%0d_flush", i), 32'(flush_o), 32'(tbl[i].flush));
      chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(tbl[i].st));
      chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt_o), 32'(tbl[i].sc));
      chk($sformatf("vec%0d_flush_cnt", i), 32'(flush_cnt_o), 32'(tbl[i].fc));
      next_cycle();
    end

    // Stall counter saturation: 11 + 21 busy cycles would wrap to 0 without saturation
    for (int i = 0; i < 21; i++) begin
      drive(z);
      mem_busy_i = 1'b1;
      #2;
      next_cycle();
    end
    drive(z);
    #2;
    $display("[TB] sat stall: scnt=%0d state=%b stall=%b", stall_cnt_o, state_o, stall_o);
    chk("sat_stall_cnt", 32'(stall_cnt_o), 32'hF);
    chk("sat_state_wait", 32'(state_o), 32'h3);
    chk("sat_idle_stall", 32'(stall_o), 32'h0);
    next_cycle();

    // Flush counter saturation: back-to-back branches, 4 + 15 would wrap to 3
    for (int i = 0; i < 15; i++) begin
      drive(z);
      branch_en_i = 1'b1;
      #2;
      next_cycle();
    end
    drive(z);
    #2;
    $display("[TB] sat flush: fcnt=%0d scnt=%0d state=%b flush=%b",
             flush_cnt_o, stall_cnt_o, state_o, flush_o);
    chk("sat_flush_cnt", 32'(flush_cnt_o), 32'hF);
    chk("sat_stall_cnt_hold", 32'(stall_cnt_o), 32'hF);
    chk("refill_state", 32'(state_o), 32'h2);
    chk("refill_flush", 32'(flush_o), 32'h02);

    // Reset asserted mid-FLUSH with a load-use pattern present
    drive(luh);
    #1;
    resetn_i = 1'b0;
    #1;
    $display("[TB] async rst: stall=%b flush=%b state=%b", stall_o, flush_o, state_o);
    chk("arst_stall", 32'(stall_o), 32'h00);
    chk("arst_flush", 32'(flush_o), 32'h1F);
    chk("arst_state", 32'(state_o), 32'h0);
    chk("arst_stall_cnt", 32'(stall_cnt_o), 32'h0);
    chk("arst_flush_cnt", 32'(flush_cnt_o), 32'h0);
    next_cycle();
    resetn_i = 1'b1;
    #2;
    $display("[TB] after rst: stall=%b flush=%b state=%b", stall_o, flush_o, state_o);
    chk("rel_state", 32'(state_o), 32'h0);
    chk("rel_lu_stall", 32'(stall_o), 32'h03);
    chk("rel_lu_flush", 32'(flush_o), 32'h04);
    drive(z);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
